navigate_seq: RTL and testbench

Move sequencer for the PID steering datapath. It generates the `moving` and `frwrd` inputs that the PID block consumes. It ramps forward speed up and down at the `err_vld` rate, holds speed at zero during in-place heading changes, and reports completion to the command layer. It sits between the command/maze-solver logic and the PID block, and shares the PID's `err_vld` strobe.

---
 rtl/navigate_seq.sv | 129 ++++++++++++
 tb/tb_navigate_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/navigate_seq.sv
// Move sequencer feeding the PID block: ramps forward speed at the err_vld rate,
// holds zero speed during in-place heading changes and pulses on move completion.
module navigate_seq #(
    parameter bit         FAST_SIM  = 1'b1,
    parameter logic [9:0] MAX_FRWRD = 10'h1A0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strt_hdng,
    input  logic       strt_mv,
    input  logic       stp_lft,
    input  logic       stp_rght,
    input  logic       err_vld,
    input  logic       at_hdng,
    input  logic       lft_opn,
    input  logic       rght_opn,
    input  logic       frwrd_opn,
    output logic       moving,
    output logic [9:0] frwrd,
    output logic       en_fusion,
    output logic       mv_cmplt
);

    localparam logic [10:0] INC  = FAST_SIM ? 11'h020 : 11'h004;
    localparam logic [10:0] INC4 = INC << 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDNG     = 3'd1,
        RAMP     = 3'd2,
        DEC_SLOW = 3'd3,
        DEC_FAST = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_frwrd;
    logic [9:0] w_frwrd_nxt;
    logic       r_mv_cmplt;
    logic       w_cmplt_nxt;
    logic       r_lft_prev;
    logic       r_rght_prev;
    logic       w_side_stop;

    // Sums are formed one bit wider than frwrd so neither bound can wrap.
    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [10:0] b);
        logic [10:0] s;
        s = {1'b0, a} + b;
        if (s > {1'b0, MAX_FRWRD}) return MAX_FRWRD;
        return s[9:0];
    endfunction

    function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [10:0] b);
        if ({1'b0, a} <= b) return 10'h000;
        return a - b[9:0];
    endfunction

    // Previous-opening flops reset to 1 so openings already present never look like a rise.
    assign w_side_stop = (stp_lft  & lft_opn  & ~r_lft_prev) |
                         (stp_rght & rght_opn & ~r_rght_prev);

    always_comb begin
        w_state_nxt = r_state;
        w_frwrd_nxt = r_frwrd;
        w_cmplt_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_frwrd_nxt = 10'h000;
                if (strt_hdng)    w_state_nxt = HDNG;
                else if (strt_mv) w_state_nxt = RAMP;
            end
            HDNG: begin
                w_frwrd_nxt = 10'h000;
                if (err_vld && at_hdng) begin
                    w_state_nxt = IDLE;
                    w_cmplt_nxt = 1'b1;
                end
            end
            RAMP: begin
                if (err_vld)          w_frwrd_nxt = sat_add(r_frwrd, INC);
                if (!frwrd_opn)       w_state_nxt = DEC_FAST;
                else if (w_side_stop) w_state_nxt = DEC_SLOW;
            end
            DEC_SLOW: begin
                if (r_frwrd == 10'h000) begin
                    w_state_nxt = IDLE;
                    w_cmplt_nxt = 1'b1;
                end else begin
                    if (err_vld)    w_frwrd_nxt = sat_sub(r_frwrd, INC);
                    if (!frwrd_opn) w_state_nxt = DEC_FAST;
                end
            end
            DEC_FAST: begin
                if (r_frwrd == 10'h000) begin
                    w_state_nxt = IDLE;
                    w_cmplt_nxt = 1'b1;
                end else if (err_vld) begin
                    w_frwrd_nxt = sat_sub(r_frwrd, INC4);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_frwrd_nxt = 10'h000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_frwrd     <= 10'h000;
            r_mv_cmplt  <= 1'b0;
            r_lft_prev  <= 1'b1;
            r_rght_prev <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_frwrd     <= w_frwrd_nxt;
            r_mv_cmplt  <= w_cmplt_nxt;
            r_lft_prev  <= lft_opn;
            r_rght_prev <= rght_opn;
        end
    end

    assign moving    = (r_state != IDLE);
    assign frwrd     = r_frwrd;
    assign mv_cmplt  = r_mv_cmplt;
    assign en_fusion = (r_frwrd > (MAX_FRWRD >> 1));

endmodule

// File: tb/tb_navigate_seq.sv
// Self-checking bench for navigate_seq: directed scenarios followed by random
// traffic, all compared against a speed/slope model of the move sequencer.
module tb_navigate_seq;

    localparam int INC  = 32;
    localparam int MAXF = 416;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       strt_hdng = 1'b0, strt_mv = 1'b0, stp_lft = 1'b0, stp_rght = 1'b0;
    logic       err_vld = 1'b0, at_hdng = 1'b0;
    logic       lft_opn = 1'b1, rght_opn = 1'b1, frwrd_opn = 1'b1;
    logic       moving, en_fusion, mv_cmplt;
    logic [9:0] frwrd;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a move is a speed plus a slope (+INC, -INC or -4*INC).
    bit m_active, m_hdng, m_cmplt, m_lprev, m_rprev;
    int m_spd, m_step;

    always #5 clk = ~clk;

    navigate_seq #(.FAST_SIM(1'b1), .MAX_FRWRD(10'h1A0)) dut (
        .clk(clk), .rst_n(rst_n), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
        .stp_lft(stp_lft), .stp_rght(stp_rght), .err_vld(err_vld), .at_hdng(at_hdng),
        .lft_opn(lft_opn), .rght_opn(rght_opn), .frwrd_opn(frwrd_opn),
        .moving(moving), .frwrd(frwrd), .en_fusion(en_fusion), .mv_cmplt(mv_cmplt)
    );

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_hdng = 0; m_cmplt = 0;
        m_spd = 0; m_step = 0; m_lprev = 1; m_rprev = 1;
    endtask

    task automatic model_edge();
        bit lrise, rrise;
        lrise   = lft_opn && !m_lprev;
        rrise   = rght_opn && !m_rprev;
        m_cmplt = 0;
        if (!m_active) begin
            if (strt_hdng) begin
                m_active = 1; m_hdng = 1;
            end else if (strt_mv) begin
                m_active = 1; m_hdng = 0; m_step = INC;
            end
        end else if (m_hdng) begin
            if (err_vld && at_hdng) begin
                m_active = 0; m_cmplt = 1;
            end
        end else if (m_step < 0 && m_spd == 0) begin
            m_active = 0; m_cmplt = 1;
        end else begin
            if (err_vld) begin
                m_spd = m_spd + m_step;
                if (m_spd > MAXF) m_spd = MAXF;
                if (m_spd < 0)    m_spd = 0;
            end
            if (m_step > 0) begin
                if (!frwrd_opn) m_step = -4 * INC;
                else if ((stp_lft && lrise) || (stp_rght && rrise)) m_step = -INC;
            end else if (m_step == -INC && !frwrd_opn) begin
                m_step = -4 * INC;
            end
        end
        m_lprev = lft_opn;
        m_rprev = rght_opn;
    endtask

    task automatic check_all();
        chk("moving",    {9'b0, moving},    {9'b0, m_active});
        chk("frwrd",     frwrd,             m_spd[9:0]);
        chk("en_fusion", {9'b0, en_fusion}, {9'b0, (m_spd > MAXF / 2)});
        chk("mv_cmplt",  {9'b0, mv_cmplt},  {9'b0, m_cmplt});
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic strobes(input int k);
        repeat (k) begin
            err_vld = 1'b0;
            run(3);
            err_vld = 1'b1;
            cyc();
            err_vld = 1'b0;
        end
    endtask

    task automatic pulse_mv();
        strt_mv = 1'b1;
        cyc();
        strt_mv = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_moving", {9'b0, moving}, 10'h000);
        chk("rst_frwrd", frwrd, 10'h000);
        chk("rst_cmplt", {9'b0, mv_cmplt}, 10'h000);
        chk("rst_fusion", {9'b0, en_fusion}, 10'h000);
        run(2);
        rst_n = 1'b1;
        run(2);

        // Ramp to ceiling; a strt_mv mid-ramp must not disturb the sequence
        pulse_mv();
        chk("ramp_moving", {9'b0, moving}, 10'h001);
        strobes(6);
        chk("ramp_c0", frwrd, 10'h0C0);
        chk("fusion_lo", {9'b0, en_fusion}, 10'h000);
        pulse_mv();
        strobes(1);
        chk("ramp_e0", frwrd, 10'h0E0);
        chk("fusion_hi", {9'b0, en_fusion}, 10'h001);
        strobes(6);
        chk("ramp_max", frwrd, 10'h1A0);
        strobes(2);
        chk("ramp_hold", frwrd, 10'h1A0);

        // Obstacle stop
        frwrd_opn = 1'b0;
        strobes(1);
        chk("fast_120", frwrd, 10'h120);
        strobes(3);
        chk("fast_zero", frwrd, 10'h000);
        cyc();
        chk("fast_cmplt", {9'b0, mv_cmplt}, 10'h001);
        chk("fast_idle", {9'b0, moving}, 10'h000);
        cyc();
        chk("fast_cmplt_end", {9'b0, mv_cmplt}, 10'h000);
        frwrd_opn = 1'b1;

        // Asynchronous reset mid-ramp
        pulse_mv();
        strobes(5);
        chk("pre_rst_a0", frwrd, 10'h0A0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_frwrd", frwrd, 10'h000);
        chk("midrst_moving", {9'b0, moving}, 10'h000);
        chk("midrst_cmplt", {9'b0, mv_cmplt}, 10'h000);
        chk("midrst_fusion", {9'b0, en_fusion}, 10'h000);
        run(2);
        rst_n = 1'b1;
        strobes(2);
        chk("post_rst_idle", {9'b0, moving}, 10'h000);
        pulse_mv();
        strobes(1);
        chk("restart_20", frwrd, 10'h020);
        frwrd_opn = 1'b0;
        strobes(1);
        run(2);
        frwrd_opn = 1'b1;

        // Side stop: pre-existing opening ignored, fresh opening decelerates
        stp_lft = 1'b1;
        pulse_mv();
        strobes(8);
        chk("side_100", frwrd, 10'h100);
        chk("side_nostop", {9'b0, moving}, 10'h001);
        lft_opn = 1'b0;
        cyc();
        lft_opn = 1'b1;
        cyc();
        strobes(7);
        chk("slow_20", frwrd, 10'h020);
        strobes(1);
        chk("slow_zero", frwrd, 10'h000);
        cyc();
        chk("slow_cmplt", {9'b0, mv_cmplt}, 10'h001);
        cyc();
        chk("slow_cmplt_end", {9'b0, mv_cmplt}, 10'h000);
        stp_lft = 1'b0;

        // Obstacle during slow deceleration
        stp_rght = 1'b1;
        pulse_mv();
        strobes(8);
        rght_opn = 1'b0;
        cyc();
        rght_opn = 1'b1;
        cyc();
        strobes(4);
        chk("slow_80", frwrd, 10'h080);
        frwrd_opn = 1'b0;
        cyc();
        strobes(1);
        chk("slow2fast_zero", frwrd, 10'h000);
        cyc();
        chk("slow2fast_cmplt", {9'b0, mv_cmplt}, 10'h001);
        frwrd_opn = 1'b1;
        stp_rght = 1'b0;
        cyc();

        // Heading: no completion without err_vld; new move accepted during mv_cmplt
        at_hdng = 1'b1;
        strt_hdng = 1'b1;
        cyc();
        strt_hdng = 1'b0;
        run(5);
        chk("hdng_moving", {9'b0, moving}, 10'h001);
        chk("hdng_frwrd", frwrd, 10'h000);
        chk("hdng_nocmplt", {9'b0, mv_cmplt}, 10'h000);
        err_vld = 1'b1;
        cyc();
        err_vld = 1'b0;
        chk("hdng_cmplt", {9'b0, mv_cmplt}, 10'h001);
        chk("hdng_idle", {9'b0, moving}, 10'h000);
        pulse_mv();
        chk("accept_in_cmplt", {9'b0, moving}, 10'h001);
        chk("cmplt_one_cycle", {9'b0, mv_cmplt}, 10'h000);
        frwrd_opn = 1'b0;
        run(3);
        frwrd_opn = 1'b1;

        // Simultaneous requests: heading wins
        at_hdng = 1'b0;
        strt_hdng = 1'b1;
        strt_mv = 1'b1;
        cyc();
        strt_hdng = 1'b0;
        strt_mv = 1'b0;
        strobes(3);
        chk("both_hdng_frwrd", frwrd, 10'h000);
        chk("both_hdng_moving", {9'b0, moving}, 10'h001);
        at_hdng = 1'b1;
        strobes(1);
        chk("both_hdng_cmplt", {9'b0, mv_cmplt}, 10'h001);
        cyc();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            err_vld   = ($urandom_range(0, 2) == 0);
            strt_hdng = ($urandom_range(0, 19) == 0);
            strt_mv   = ($urandom_range(0, 9) == 0);
            at_hdng   = ($urandom_range(0, 3) == 0);
            stp_lft   = $urandom_range(0, 1);
            stp_rght  = $urandom_range(0, 1);
            if ($urandom_range(0, 29) == 0) frwrd_opn = ~frwrd_opn;
            if ($urandom_range(0, 15) == 0) lft_opn = ~lft_opn;
            if ($urandom_range(0, 15) == 0) rght_opn = ~rght_opn;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                cyc();
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
